// File: rtl/debug_step_controller.sv
// debug_step_controller
//   Generates the CPU clock-enable pulse train for the debug clocking scheme.
//   The CPU always runs on i_CLK; this block only decides in which cycles the
//   core is allowed to advance.
//
//   Ports
//     i_CLK        system clock
//     i_RST        asynchronous active-high reset
//     i_Mode       raw mode switches: 00 HALT, 01 STEP, 10 SLOW, 11 RUN
//     i_Step_Btn   raw, bouncy step push-button (active-high)
//     i_Halt       synchronous breakpoint hit from the CPU side
//     o_CLK_EN     registered single-cycle CPU clock enable
//     o_Halted     breakpoint latch
//     o_Step_Count number of delivered enables, wraps at 16 bits
//
//   Debounce FSM
//     state        | meaning
//     DB_IDLE      | button released and accepted as released
//     DB_ARMING    | button seen high, counting stable-high cycles
//     DB_PRESSED   | press accepted, step already requested
//     DB_RELEASING | button seen low, counting stable-low cycles
module debug_step_controller #(
    parameter int DIV             = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 32
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic [1:0]  i_Mode,
    input  logic        i_Step_Btn,
    input  logic        i_Halt,
    output logic        o_CLK_EN,
    output logic        o_Halted,
    output logic [15:0] o_Step_Count
);

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_RUN  = 2'b11;

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_ARMING    = 2'd1,
        DB_PRESSED   = 2'd2,
        DB_RELEASING = 2'd3
    } db_state_e;

    logic [1:0]       mode_meta_q, mode_q;
    logic             btn_meta_q, btn_q;
    db_state_e        db_state_q, db_state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             step_req;
    logic [CNT_W-1:0] div_q, div_d;
    logic             en_q, en_d;
    logic             halted_q, halted_d;
    logic [15:0]      count_q, count_d;
    logic             mode_chg;

    // Two-flop synchronizers for the asynchronous switches and button
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            mode_meta_q <= MODE_HALT;
            mode_q      <= MODE_HALT;
            btn_meta_q  <= 1'b0;
            btn_q       <= 1'b0;
        end else begin
            mode_meta_q <= i_Mode;
            mode_q      <= mode_meta_q;
            btn_meta_q  <= i_Step_Btn;
            btn_q       <= btn_meta_q;
        end
    end

    // Debounce FSM: state register
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            db_state_q <= DB_IDLE;
            db_cnt_q   <= '0;
        end else begin
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Debounce FSM: next state. Comparing against DEBOUNCE_CYCLES-1 means the
    // count "reaches" DEBOUNCE_CYCLES in the same cycle the transition happens.
    always_comb begin
        db_state_d = db_state_q;
        db_cnt_d   = db_cnt_q;
        case (db_state_q)
            DB_IDLE: begin
                if (btn_q) begin
                    db_state_d = DB_ARMING;
                    db_cnt_d   = CNT_W'(1);
                end
            end
            DB_ARMING: begin
                if (!btn_q) begin
                    db_state_d = DB_IDLE;
                    db_cnt_d   = '0;
                end else if (db_cnt_q == DEB_LAST) begin
                    db_state_d = DB_PRESSED;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            DB_PRESSED: begin
                if (!btn_q) begin
                    db_state_d = DB_RELEASING;
                    db_cnt_d   = CNT_W'(1);
                end
            end
            DB_RELEASING: begin
                if (btn_q) begin
                    db_state_d = DB_PRESSED;
                    db_cnt_d   = '0;
                end else if (db_cnt_q == DEB_LAST) begin
                    db_state_d = DB_IDLE;
                    db_cnt_d   = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                db_state_d = DB_IDLE;
                db_cnt_d   = '0;
            end
        endcase
    end

    // Debounce FSM: output, one cycle on the ARMING->PRESSED transition
    always_comb begin
        step_req = (db_state_q == DB_ARMING) && btn_q && (db_cnt_q == DEB_LAST);
    end

    // A change is detected one stage early so the divider and the breakpoint
    // latch are already cleared in the first cycle the new mode is in effect.
    assign mode_chg = (mode_meta_q != mode_q);

    always_comb begin
        case (mode_q)
            MODE_STEP: en_d = step_req;
            // i_Halt also kills the pulse that would otherwise land with it
            MODE_SLOW: en_d = (div_q == DIV_LAST) && !halted_q && !i_Halt;
            MODE_RUN:  en_d = !halted_q && !i_Halt;
            default:   en_d = 1'b0;
        endcase

        halted_d = halted_q;
        if (mode_chg) begin
            halted_d = 1'b0;
        end else if (mode_q[1] && i_Halt) begin
            halted_d = 1'b1;
        end

        if (mode_chg || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + CNT_W'(1);
        end

        count_d = count_q + {15'd0, en_q};
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            en_q     <= 1'b0;
            halted_q <= 1'b0;
            div_q    <= '0;
            count_q  <= '0;
        end else begin
            en_q     <= en_d;
            halted_q <= halted_d;
            div_q    <= div_d;
            count_q  <= count_d;
        end
    end

    assign o_CLK_EN     = en_q;
    assign o_Halted     = halted_q;
    assign o_Step_Count = count_q;

endmodule
